// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional signed operation is enabled with SEQ_DIVIDER_SIGNED_EN.
package seq_divider_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: partial remainder A, quotient/dividend Q, divisor D.
// With SEQ_DIVIDER_SIGNED_EN, operands are reduced to magnitudes and results sign-fixed.
module div_datapath
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             iter_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    // A always ends an iteration below D, so its top bit is only needed in the shifted trial.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic sn_q, sn_d;
    logic sd_q, sd_d;

    assign dvd_mag = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
    assign dvs_mag = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;

    always_comb begin
        sn_d = sn_q;
        sd_d = sd_q;
        if (load_i) begin
            sn_d = dividend_i[WIDTH-1];
            sd_d = divisor_i[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sn_q <= 1'b0;
            sd_q <= 1'b0;
        end else begin
            sn_q <= sn_d;
            sd_q <= sd_d;
        end
    end

    // Quotient sign follows the sign mismatch; remainder takes the dividend sign.
    assign quo_o = (sn_q ^ sd_q) ? -q_q : q_q;
    assign rem_o = sn_q ? -a_q : a_q;
`else
    assign dvd_mag = dividend_i;
    assign dvs_mag = divisor_i;
    assign quo_o   = q_d;
    assign rem_o   = a_d;
`endif

    always_comb begin
        shifted = {a_q, q_q[WIDTH-1]};
        trial   = shifted - {1'b0, d_q};
        a_d     = a_q;
        q_d     = q_q;
        d_d     = d_q;
        if (load_i) begin
            a_d = '0;
            q_d = dvd_mag;
            d_d = dvs_mag;
        end else if (iter_i) begin
            if (!trial[WIDTH]) begin
                a_d = trial[WIDTH-1:0];
                q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                a_d = shifted[WIDTH-1:0];
                q_d = {q_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            q_q <= '0;
            d_q <= '0;
        end else begin
            a_q <= a_d;
            q_q <= q_d;
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider top: Execute-hold FSM, iteration counter, result registers.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (adds a FIX state).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Execute,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] dp_quo;
    logic [WIDTH-1:0] dp_rem;

    div_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk        (Clk),
        .rst        (Reset),
        .load_i     (state_q == LOAD),
        .iter_i     (state_q == ITER),
        .dividend_i (Dividend),
        .divisor_i  (Divisor),
        .quo_o      (dp_quo),
        .rem_o      (dp_rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (Execute) state_d = LOAD;
            LOAD: begin
                state_d = ITER;
                cnt_d   = '0;
                dz_d    = (Divisor == '0);
            end
            ITER: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    state_d = FIX;
`else
                    state_d = DONE;
`endif
                end
            end
            FIX:  state_d = DONE;
            DONE: if (!Execute) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Results are captured only on the edge that enters DONE.
        if (state_d == DONE && state_q != DONE) begin
            quo_d = dp_quo;
            rem_d = dp_rem;
        end
        busy_d = (state_d == LOAD) || (state_d == ITER) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign Quotient  = quo_q;
    assign Remainder = rem_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivZero   = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=8), one line per operation.
module tb_seq_divider;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 10;
`endif

    logic       Clk;
    logic       Reset;
    logic       Execute;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivZero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Execute   (Execute),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts an operation, holds Execute for 'hold' edges, then checks timing and results.
    task automatic run_op(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                          input int hold, input logic [7:0] eq, input logic [7:0] er,
                          input logic edz);
        int lat;
        int done_cycles;
        int exp_done;
        lat = 0;
        done_cycles = 0;
        @(negedge Clk);
        Dividend = dvd;
        Divisor  = dvs;
        Execute  = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (e == 1) check({tag, ".busy"}, {31'd0, Busy}, 32'd1);
            if (e == 3) begin
                Dividend = ~dvd;
                Divisor  = ~dvs;
            end
            if (Done) begin
                done_cycles++;
                if (lat == 0) lat = e;
            end
            if (e >= hold) Execute = 1'b0;
            if (lat != 0 && e >= hold) break;
        end
        exp_done = (hold > LAT) ? (hold - LAT + 1) : 1;
        check({tag, ".latency"}, lat, LAT);
        check({tag, ".done_cycles"}, done_cycles, exp_done);
        @(posedge Clk);
        @(negedge Clk);
        check({tag, ".done_off"}, {31'd0, Done}, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        check({tag, ".no_restart"}, {31'd0, Busy}, 32'd0);
        check({tag, ".quotient"}, {24'd0, Quotient}, {24'd0, eq});
        check({tag, ".remainder"}, {24'd0, Remainder}, {24'd0, er});
        check({tag, ".divzero"}, {31'd0, DivZero}, {31'd0, edz});
        $display("op %s: %0d / %0d -> q=%02h r=%02h dz=%0d latency=%0d done_cycles=%0d",
                 tag, dvd, dvs, Quotient, Remainder, DivZero, lat, done_cycles);
    endtask

    initial begin
        Reset    = 1'b1;
        Execute  = 1'b0;
        Dividend = 8'd0;
        Divisor  = 8'd0;
        repeat (2) @(negedge Clk);
        check("reset.quotient",  {24'd0, Quotient},  32'd0);
        check("reset.remainder", {24'd0, Remainder}, 32'd0);
        check("reset.busy",      {31'd0, Busy},      32'd0);
        check("reset.done",      {31'd0, Done},      32'd0);
        check("reset.divzero",   {31'd0, DivZero},   32'd0);
        Reset = 1'b0;

        run_op("div100_7",  8'd100, 8'd7, 1,  8'd14,  8'd2, 1'b0);
        run_op("div255_1",  8'd255, 8'd1, 20, 8'hFF,  8'd0, 1'b0);
        run_op("div5_0",    8'd5,   8'd0, 1,  8'hFF,  8'd5, 1'b1);
        run_op("div9_3",    8'd9,   8'd3, 1,  8'd3,   8'd0, 1'b0);
        run_op("div7_9",    8'd7,   8'd9, 1,  8'd0,   8'd7, 1'b0);

        // Asynchronous reset in the middle of the iterations.
        @(negedge Clk);
        Dividend = 8'd200;
        Divisor  = 8'd3;
        Execute  = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Execute = 1'b0;
        repeat (5) begin
            @(posedge Clk);
            @(negedge Clk);
        end
        check("midreset.busy_before", {31'd0, Busy}, 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("midreset.quotient",  {24'd0, Quotient},  32'd0);
        check("midreset.remainder", {24'd0, Remainder}, 32'd0);
        check("midreset.busy",      {31'd0, Busy},      32'd0);
        check("midreset.done",      {31'd0, Done},      32'd0);
        check("midreset.divzero",   {31'd0, DivZero},   32'd0);
        $display("op midreset: 200 / 3 aborted by asynchronous reset");
        @(negedge Clk);
        Reset = 1'b0;

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op("div200_3",  8'd200, 8'd3, 1, 8'hEE, 8'hFE, 1'b0);
        run_op("divm100_7", 8'h9C,  8'd7, 1, 8'hF2, 8'hFE, 1'b0);
        run_op("divm128_m1", 8'h80, 8'hFF, 1, 8'h80, 8'h00, 1'b0);
`else
        run_op("div200_3",  8'd200, 8'd3, 1, 8'd66, 8'd2, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
